result_stream_reader: RTL
=========================

Name: result_stream_reader

Overview:
- Drains the result RAM written by the multiplier controller and streams each word out over a valid/ready interface.
- Started by the controller's one-cycle done pulse; reads NUM_WORDS consecutive addresses from BASE_ADDR.
- Absorbs the 1-cycle synchronous RAM read latency and downstream backpressure with a 2-entry buffer, losing no words.

Parameters:
- DATA_W, 32, result word width.
- ADDR_W, 3, result RAM address width.
- NUM_WORDS, 4, words per transfer; 1..2^ADDR_W.
- BASE_ADDR, 0, first RAM address read.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low: all state clears while rst=0.
- start  in  1  transfer request; sampled only in IDLE.
- ram_rd_en  out  1  RAM read strobe.
- ram_rd_addr  out  ADDR_W  RAM read address.
- ram_rd_data  in  DATA_W  RAM data; valid the cycle after ram_rd_en=1.
- out_data  out  DATA_W  streamed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  marks the word with index NUM_WORDS-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset values: ram_rd_en=0, ram_rd_addr=BASE_ADDR, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
  - On reset, the FSM returns to IDLE, counters go to 0 and the buffer empties.
  - Reset mid-transfer drops in-flight and buffered words; no done pulse is issued.
- FSM states: IDLE, STREAM, FLUSH, DONE.
- IDLE:
  - start=1 → STREAM.
  - On that edge, issue_cnt=0 and inflight=0.
- STREAM:
  - issue = (issue_cnt < NUM_WORDS) && (occupancy + inflight - pop < 2), where pop = out_valid && out_ready.
  - ram_rd_en = issue.
  - ram_rd_addr = BASE_ADDR + issue_cnt, truncated to ADDR_W (wraps).
  - On issue, issue_cnt increments.
  - inflight register <= issue. Its tag last = (issue_cnt == NUM_WORDS-1).
  - When issue_cnt reaches NUM_WORDS → FLUSH.
- FLUSH:
  - No reads are issued.
  - When the tagged last word is popped → DONE.
- DONE:
  - done=1 for exactly one cycle, then → IDLE.
- Capture: ram_rd_data and the last tag are written into the buffer in the cycle after the issue.
- Output rules:
  - out_valid = buffer not empty.
  - out_data and out_last come from the buffer head.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never drops without a pop.
- Latency:
  - start at edge t0 → first ram_rd_en in cycle t0+1 → first out_valid in cycle t0+3.
  - With out_ready=1 throughout: one word per cycle, and done follows 1 cycle after the last pop.
- Simultaneous push and pop on a full buffer is legal; occupancy is unchanged.
- The buffer never overflows, because the credit check already counts the inflight read.
- start while busy=1 is ignored; it is neither queued nor restarts the transfer.
- issue_cnt is ADDR_W+1 bits wide, so NUM_WORDS = 2^ADDR_W terminates correctly.
- NUM_WORDS=1: the single word carries out_last=1.

Decomposition:
- Shared package (mult_pkg): reader_state_t enum (IDLE, STREAM, FLUSH, DONE), encoded in 2 bits.
  - The package also carries the default DATA_W and ADDR_W, shared with the controller and RAM.
- One sub-module: result_skid_fifo.
  - 2-entry FIFO of {last, data}, with push, pop, count, head outputs and the same clk/rst.

Test Plan:
- Basic stream: RAM[0..3]=0x11,0x22,0x33,0x44, out_ready=1, start pulse at t0 → ram_rd_en in cycles t0+1..t0+4; out_data 0x11..0x44 in cycles t0+3..t0+6; out_last only on 0x44; done in cycle t0+7; busy low afterwards.
- Backpressure: same data, out_ready low for 5 cycles starting when 0x11 first presents → 0x11 stays stable; at most 2 reads issued beyond accepted words; on release, the remaining words arrive in order with no loss or duplication.
- Alternating out_ready (1,0,1,0...) → all 4 words delivered in order; ram_rd_en never pushes the buffer beyond 2 entries.
- start pulsed again mid-transfer → ignored; exactly 4 words and one done.
- rst driven to 0 for 1 cycle after the second word is accepted → outputs reach reset values immediately; a new start then streams from BASE_ADDR again with 0x11 first.
- Edge parameters:
  - NUM_WORDS=1 → one word with out_last=1, then done.
  - ADDR_W=2, NUM_WORDS=4, BASE_ADDR=2 → addresses 2,3,0,1 (wrap).

Source files
------------

// File: rtl/mult_pkg.sv
// Types and default widths shared by the multiplier controller, result RAM and reader.
package mult_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } reader_state_t;

endpackage

// File: rtl/result_stream_reader_if.sv
// RAM read port plus outgoing valid/ready word stream of the result reader.
interface result_stream_reader_if #(
    parameter int DATA_W = mult_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = mult_pkg::DEFAULT_ADDR_W
);
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output ram_rd_en, ram_rd_addr, out_data, out_valid, out_last,
        input  ram_rd_data, out_ready
    );

    modport slave (
        input  ram_rd_en, ram_rd_addr, out_data, out_valid, out_last,
        output ram_rd_data, out_ready
    );
endinterface

// File: rtl/result_skid_fifo.sv
// Two-entry FIFO of {last, data}; the reader's credit check keeps it from overflowing.
module result_skid_fifo
    import mult_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last
);
    logic [DATA_W:0] mem [2];
    logic            wr_ptr;
    logic            rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_last, push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign {head_last, head_data} = mem[rd_ptr];
endmodule

// File: rtl/result_stream_reader.sv
// Drains NUM_WORDS result words from the synchronous RAM and streams them out on valid/ready.
module result_stream_reader
    import mult_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int NUM_WORDS = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    result_stream_reader_if.master bus,
    output logic                   busy,
    output logic                   done
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] WORDS    = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    reader_state_t     state, state_nxt;
    logic [CNT_W-1:0]  issue_cnt;
    logic              inflight;
    logic              inflight_last;
    logic              issue;
    logic              pop;
    logic [1:0]        count;
    logic [2:0]        credit;
    logic [DATA_W-1:0] head_data;
    logic              head_last;

    assign pop = bus.out_valid && bus.out_ready;
    // Slots already claimed once this cycle's pop leaves: the inflight read counts as taken.
    assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue  = (state == STREAM) && (issue_cnt < WORDS) && (credit < 3'd2);

    assign bus.ram_rd_en   = issue;
    assign bus.ram_rd_addr = ADDR_W'(BASE_ADDR) + issue_cnt[ADDR_W-1:0];
    assign bus.out_valid   = (count != 2'd0);
    assign bus.out_data    = head_data;
    assign bus.out_last    = head_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            issue_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nxt;
            inflight      <= issue;
            inflight_last <= issue && (issue_cnt == LAST_IDX);
            if (state == IDLE && start)
                issue_cnt <= '0;
            else if (issue)
                issue_cnt <= issue_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nxt = STREAM;
            end
            STREAM: begin
                if (issue && issue_cnt == LAST_IDX)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                if (pop && head_last)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    result_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.ram_rd_data),
        .push_last (inflight_last),
        .pop       (pop),
        .count     (count),
        .head_data (head_data),
        .head_last (head_last)
    );
endmodule
